// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache and its line-fill controller.
// The fill-state encodings, burst length and address field widths match the
// data cache, which uses the same off-chip block-read protocol.
package instr_cache_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned LINE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } fill_state_e;

  // Expand a line address back to the word-0 bus address of that line.
  function automatic logic [ADDR_W-1:0] line_to_addr(input logic [LINE_W-1:0] line);
    return {line, OFF_W'(0)};
  endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Line-fill controller: block-read handshake FSM, word counter and the
// address drive onto the shared off-chip bus.
module icache_fill_ctrl
  import instr_cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LINE_W-1:0] line_in,
  input  logic              rrdy,
  input  logic              rdrdy,
  output logic              idle_c,
  output logic              word_we_c,
  output logic              line_done_c,
  output logic [CNT_W-1:0]  cnt,
  output logic [LINE_W-1:0] line_addr,
  output logic              rrqst,
  output logic              rdacpt,
  output logic              macc,
  inout  wire  [DATA_W-1:0] offdata
);

  fill_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              rrqst_q, rrqst_d;
  logic              rdacpt_q, rdacpt_d;
  logic              macc_q, macc_d;

  // Next-state, counter and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    word_we_c   = 1'b0;
    line_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          line_d  = line_in;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rrdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rdrdy) begin
          word_we_c = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!rdrdy) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            line_done_c = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rrqst_d  = (state_d == ST_REQ);
    rdacpt_d = (state_d == ST_ACK);
    macc_d   = (state_d != ST_IDLE);
  end

  // State, counter, latched line address and handshake output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      rrqst_q  <= 1'b0;
      rdacpt_q <= 1'b0;
      macc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      rrqst_q  <= rrqst_d;
      rdacpt_q <= rdacpt_d;
      macc_q   <= macc_d;
    end
  end

  assign idle_c    = (state_q == ST_IDLE);
  assign cnt       = cnt_q;
  assign line_addr = line_q;
  assign rrqst     = rrqst_q;
  assign rdacpt    = rdacpt_q;
  assign macc      = macc_q;

  // The bus carries the line address only while requesting; otherwise it is
  // released so memory can drive data words without contention.
  assign offdata = rrqst_q ? line_to_addr(line_q) : {DATA_W{1'bz}};

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache for the LC3 fetch port.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned IDX_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              complete,
  output logic              macc,
  output logic              rrqst,
  input  logic              rrdy,
  input  logic              rdrdy,
  output logic              rdacpt,
  output logic              wrqst,
  inout  wire  [DATA_W-1:0] offdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  logic [IDX_W-1:0]  rd_idx, fill_idx;
  logic [TAG_W-1:0]  rd_tag, fill_tag;
  logic [OFF_W-1:0]  rd_off;
  logic [LINE_W-1:0] fill_line;
  logic [CNT_W-1:0]  fill_cnt;
  logic              idle_c, hit_c, start_c;
  logic              word_we_c, line_done_c;

  assign rd_idx   = addr[OFF_W +: IDX_W];
  assign rd_tag   = addr[ADDR_W-1 -: TAG_W];
  assign rd_off   = addr[OFF_W-1:0];
  assign fill_idx = fill_line[IDX_W-1:0];
  assign fill_tag = fill_line[LINE_W-1 -: TAG_W];

  // Lookup is combinational so a hit completes in the request cycle.
  assign hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign complete = idle_c && rd && hit_c;
  assign start_c  = idle_c && rd && !hit_c;
  assign dout     = data_q[rd_idx][rd_off];
  assign wrqst    = 1'b0;

  icache_fill_ctrl u_fill (
    .clock       (clock),
    .reset       (reset),
    .start       (start_c),
    .line_in     (addr[ADDR_W-1:OFF_W]),
    .rrdy        (rrdy),
    .rdrdy       (rdrdy),
    .idle_c      (idle_c),
    .word_we_c   (word_we_c),
    .line_done_c (line_done_c),
    .cnt         (fill_cnt),
    .line_addr   (fill_line),
    .rrqst       (rrqst),
    .rdacpt      (rdacpt),
    .macc        (macc),
    .offdata     (offdata)
  );

  // A line becomes valid only once its last word has been written.
  always_comb begin
    valid_d = valid_q;
    if (line_done_c) valid_d[fill_idx] = 1'b1;
  end

  // Valid bits are the only cache state cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data arrays: written during fills, never reset.
  always_ff @(posedge clock) begin
    if (word_we_c)   data_q[fill_idx][fill_cnt] <= offdata;
    if (line_done_c) tag_q[fill_idx]            <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit and miss statistics.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (complete && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
    if (start_c && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the LC3 fetch interface (pc, instrmem_rd, Instr_dout, complete_instr, I_macc) and the off-chip memory handshake (rrqst/rrdy/rdrdy/rdacpt/wrqst, shared 16-bit bus).
- Replaces the ideal single-cycle instruction memory.
- On a miss it fetches a 4-word line through the same block-read protocol the data cache uses.

Parameters:
- IDX_W, 3, line index bits (2**IDX_W lines); tag width = 14-IDX_W.
- WORDS, 4, words per line; fixed to match the memory burst, not to be overridden.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  16  fetch address (LC3 pc)
- rd  in  1  fetch request (LC3 instrmem_rd)
- dout  out  16  instruction word to LC3
- complete  out  1  fetch satisfied this cycle (LC3 complete_instr)
- macc  out  1  off-chip access in progress (LC3 I_macc)
- rrqst  out  1  read request to memory
- rrdy  in  1  memory has latched the address
- rdrdy  in  1  memory is driving a data word
- rdacpt  out  1  word accepted
- wrqst  out  1  write request; tied 0
- offdata  inout  16  shared address/data bus
- Interface: one clock; reset is asynchronous and active-high; ports named clock and reset.

Behaviour:
- Storage: valid[2**IDX_W], tag[], data[][4]. addr[1:0] = word offset, addr[IDX_W+1:2] = index, addr[15:IDX_W+2] = tag.
- Reset (async): all valid=0; FSM=IDLE; rrqst=0, rdacpt=0, macc=0, wrqst=0; offdata=Z; word counter=0. Tag/data arrays are not reset.
- Hit (combinational): in IDLE with rd=1, valid and tag match → complete=1 and dout=data[index][offset] in the same cycle. complete=0 when rd=0 or on a miss. dout is don't-care when complete=0.
- Miss: in IDLE with rd=1 and no match → latch maddr={addr[15:2],2'b00}, go to REQ next edge. complete stays 0 until the fill ends and the re-lookup hits.
- FSM states and transitions:
  - IDLE: waiting for a fetch.
  - REQ: rrqst=1, offdata driven with maddr; stay until rrdy=1, then WAIT.
  - WAIT: rrqst=0, bus Z; stay until rdrdy=1, then capture offdata into data[index][cnt] on that edge and go to ACK.
  - ACK: rdacpt=1; stay until rdrdy=0. Then rdacpt=0 and cnt++. If cnt was 3: write tag, set valid, go to IDLE; else go to WAIT.
- Handshake inputs are sampled on rising clock edges only. Memory handshake gaps exceed 2 clocks, so no synchronizer.
- Words arrive in order 0..3 regardless of the miss offset; word k goes to data[index][k].
- macc=1 in every state except IDLE.
- offdata is driven only in REQ; everywhere else it is Z, which guarantees no contention with memory during rdrdy.
- addr/rd changing during a fill is ignored; the fill always completes for maddr. The first IDLE cycle re-evaluates the current addr.
- Valid is not set until all 4 words are written, so a partial line is never hit.
- Reset mid-fill aborts immediately: line stays invalid, outputs return to reset values. Memory is reset on the same reset.
- No writes: rd only, wrqst constantly 0.

Optional Feature:
- ICACHE_STATS_EN defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0], reset to 0.
  - hit_cnt +1 on each edge where complete=1 in IDLE.
  - miss_cnt +1 on each IDLE→REQ transition.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE, REQ, WAIT, ACK), the WORDS=4 constant, and the address field-slice widths.
- These are shared with the data cache, which uses the same off-chip protocol.
- One natural sub-module: icache_fill_ctrl, holding the FSM, word counter and bus tri-state. The top level holds the arrays, hit logic and optional counters.

Test Plan:
- Cold miss:
  - Stimulus: reset, then rd=1, addr=16'h3001, memory words 0x3000..0x3003 = A0,A1,A2,A3.
  - Response: rrqst rises with offdata=16'h3000; exactly 4 rdrdy/rdacpt pairs; then complete=1, dout=A1; macc high throughout the fill.
- Line hits:
  - Stimulus: after the cold miss, addr=16'h3000, 16'h3002, 16'h3003 on consecutive cycles.
  - Response: complete=1 each cycle, dout=A0,A2,A3, rrqst never asserted.
- Conflict miss:
  - Stimulus: addr=16'h3020 (same index, IDX_W=3), then 16'h3000.
  - Response: two full fills; the second re-fetches A0.
- Address change mid-fill:
  - Stimulus: miss on 16'h4000; switch addr to 16'h4003 during WAIT.
  - Response: fill completes for 16'h4000; first IDLE cycle gives complete=1, dout=word3.
- Reset mid-fill:
  - Stimulus: assert reset during the second ACK.
  - Response: rdacpt=0, rrqst=0, offdata=Z, macc=0 immediately; the next access to the same address misses again.
- With ICACHE_STATS_EN:
  - Stimulus: the scenarios above in sequence.
  - Response: miss_cnt equals the number of fills; hit_cnt equals the number of complete cycles.
